adc_test_axil_slave: RTL

AXI4-Lite responder (slave) for the ADC test interface. It terminates the single-beat write and read transactions issued by the block-design AXI master. It holds four 32-bit read/write test registers at byte offsets 0x0, 0x4, 0x8 and 0xC, and drives their contents to the ADC test fabric. It also issues a one-cycle strobe whenever a register is written.

---
 rtl/adc_test_if_pkg.sv | 27 ++
 rtl/adc_test_axil_slave.sv | 130 +++++++++++++
 2 files changed

// File: rtl/adc_test_if_pkg.sv
// Shared constants, types and the byte-merge helper for the ADC test
// register block.
package adc_test_if_pkg;

    localparam int          ADDR_LSB  = 2;
    localparam int          NUM_REGS  = 4;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef logic [1:0] reg_idx_t;

    // Byte k of the result comes from data when strb[k] is set, else from old.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[k*8 +: 8] = data[k*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/adc_test_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit test registers to the ADC test fabric,
// with a one-cycle per-register strobe on every committed write.
module adc_test_axil_slave
    import adc_test_if_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_REGS*32-1:0]            test_regs,
    output logic [NUM_REGS-1:0]               reg_wr_pulse
);

    logic [31:0] word_regs [NUM_REGS];
    logic        aw_hold;
    logic        w_hold;
    reg_idx_t    aw_idx_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    reg_idx_t    wr_idx;
    reg_idx_t    rd_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

    assign s00_axi_awready = !aw_hold && !s00_axi_bvalid && s00_axi_aresetn;
    assign s00_axi_wready  = !w_hold  && !s00_axi_bvalid && s00_axi_aresetn;
    assign s00_axi_arready = !s00_axi_rvalid && s00_axi_aresetn;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // A half is "present" if it was captured earlier or handshakes this edge.
    assign commit  = (aw_hold || aw_hs) && (w_hold || w_hs);
    assign wr_idx  = aw_hs ? s00_axi_awaddr[ADDR_LSB +: 2] : aw_idx_reg;
    assign wr_data = w_hs  ? s00_axi_wdata  : wdata_reg;
    assign wr_strb = w_hs  ? s00_axi_wstrb  : wstrb_reg;
    assign rd_idx  = s00_axi_araddr[ADDR_LSB +: 2];

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                word_regs[i] <= '0;
            end
            aw_hold        <= 1'b0;
            w_hold         <= 1'b0;
            aw_idx_reg     <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
            reg_wr_pulse   <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            if (commit) begin
                word_regs[wr_idx] <= apply_wstrb(word_regs[wr_idx], wr_data, wr_strb);
                s00_axi_bvalid    <= 1'b1;
                s00_axi_bresp     <= RESP_OKAY;
                aw_hold           <= 1'b0;
                w_hold            <= 1'b0;
                reg_wr_pulse      <= NUM_REGS'(1) << wr_idx;
            end else begin
                if (aw_hs) begin
                    aw_hold    <= 1'b1;
                    aw_idx_reg <= s00_axi_awaddr[ADDR_LSB +: 2];
                end
                if (w_hs) begin
                    w_hold    <= 1'b1;
                    wdata_reg <= s00_axi_wdata;
                    wstrb_reg <= s00_axi_wstrb;
                end
            end
        end
    end

    // Read samples the pre-edge register contents, so a same-edge write is not seen.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            s00_axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= word_regs[rd_idx];
            s00_axi_rresp  <= RESP_OKAY;
        end else if (s00_axi_rvalid && s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_test_regs
            assign test_regs[gi*32 +: 32] = word_regs[gi];
        end
    endgenerate

endmodule
